int8_mac_seq: RTL and testbench
===============================

# int8_mac_seq

Sequencer for the 32-lane int8 dot-product MAC. Accepts one job (a chunk count), streams that many 32-byte A/B chunk pairs from an upstream valid/ready source into the MAC, and carries the running 24-bit partial sum between beats. It keeps the sum across input bubbles, even though the MAC zeroes its output register whenever its enable is low. Returns the final sum on a valid/ready result port. Sits between the operand buffers and one MAC instance inside a PE.

## Interface
Parameters:
- VEC_W, 264: width of the MAC A/B operand buses (lanes 0..31 in bits [255:0]; bits [263:256] are passed through unused).
- ACC_W, 24: partial-sum width; must match the MAC.
- LEN_W, 8: width of the chunk-count field.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  chunk count for the job; sampled with start.
- abort  in  1  synchronous job cancel.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  upstream chunk valid.
- in_ready  out  1  high exactly when state is FEED.
- in_a, in_b  in  VEC_W  chunk operands.
- mac_en  out  1  drives the MAC enable; equals in_valid & in_ready.
- mac_a, mac_b  out  VEC_W  combinational copies of in_a and in_b.
- mac_psum_in  out  ACC_W  sum fed to the MAC.
- mac_psum_out  in  ACC_W  MAC registered output.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  ACC_W  final sum, registered.

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 and len≠0: latch len, clear cnt, acc_q and pend, then go to FEED.
  - start=1 and len=0: res_data←0, go to DONE.
- FEED: a beat occurs when in_valid and in_ready are both high.
  - On each beat: mac_en=1, cnt++.
  - Beat with cnt==len-1: go to DRAIN.
- pend: register, set to 1 in any cycle following a beat, otherwise 0.
- Sum feedback:
  - mac_psum_in = pend ? mac_psum_out : acc_q.
  - When pend=1: acc_q ← mac_psum_out.
  - The pend bypass is what lets back-to-back beats chain correctly. acc_q holds the sum across bubbles.
- DRAIN: lasts exactly one cycle; res_data ← mac_psum_out, then go to DONE.
- DONE:
  - res_valid=1; res_data held stable.
  - On res_ready: go to IDLE.
- start is ignored outside IDLE.
- Arithmetic is unsigned, modulo 2^ACC_W; wrap is silent with no flag. One chunk contributes at most 32·255·255 = 2,080,800.
- abort, in any state: go to IDLE next cycle; mac_en is forced to 0 in the abort cycle; no result is produced. abort outranks a beat in the same cycle.
- rst: same effect as abort, and additionally clears all registers.

## Timing
- Reset values: busy=0, in_ready=0, mac_en=0, mac_psum_in=0, res_valid=0, res_data=0; state=IDLE, cnt=0, acc_q=0, pend=0.
- No-bubble job (start accepted in cycle 0):
  - Beats in cycles 1..len.
  - DRAIN in cycle len+1.
  - res_valid first high in cycle len+2.
- Each bubble cycle in FEED adds one cycle of latency.
- len=0: res_valid in cycle 1.
- Result handshake: res_valid and res_data stay stable until res_ready. The earliest next start is accepted one cycle after the result handshake.
- Only one job is in flight; there is no overlap of jobs.

## Test plan
- len=1, all bytes of A and B = 1 → res_data=32; res_valid in cycle 3.
- len=4, A=B=2 in every lane, in_valid held high → res_data=512 in cycle 6; mac_psum_in sequence is 0, 128, 256, 384.
- len=3, A=B=1, in_valid pattern 1,0,0,1,0,1 → res_data=96; mac_en pulses only on beats; no sum is lost across bubbles.
- len=0 → res_data=0 in cycle 1. Then res_ready held low for 5 cycles → res_valid and res_data held; start pulses during DONE are ignored.
- len=9, all bytes 255 → res_data=1,949,984 (18,727,200 mod 2^24).
- Mid-job interruptions:
  - rst asserted during FEED of a len=5 job → all outputs return to reset values next cycle.
  - abort during DRAIN → no res_valid.
  - A new len=1 job started afterwards returns the correct result.

Source files
------------

// File: rtl/int8_mac_seq.sv
// int8_mac_seq: job sequencer for the 32-lane int8 dot-product MAC.
// Streams len chunk pairs into the MAC and carries the 24-bit partial sum
// between beats. The MAC zeroes its output whenever its enable is low, so
// the sum is parked in r_acc across input bubbles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; len latched on acceptance
// FEED   | in_ready high; each valid&ready cycle is one MAC beat
// DRAIN  | one cycle; final MAC output captured into r_res
// DONE   | res_valid high, r_res held until res_ready
module int8_mac_seq #(
  parameter int VEC_W = 264,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_a,
  input  logic [VEC_W-1:0] in_b,
  output logic             mac_en,
  output logic [VEC_W-1:0] mac_a,
  output logic [VEC_W-1:0] mac_b,
  output logic [ACC_W-1:0] mac_psum_in,
  input  logic [ACC_W-1:0] mac_psum_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_pend;
  logic [ACC_W-1:0] r_res;
  logic             w_beat;
  logic             w_last;
  logic             w_accept;

  // Beats are suppressed in an abort or reset cycle so the MAC never sees a
  // stray enable while the job is being torn down.
  assign in_ready    = (r_state == S_FEED);
  assign w_beat      = in_valid & in_ready & ~abort & ~rst;
  assign mac_en      = w_beat;
  assign mac_a       = in_a;
  assign mac_b       = in_b;
  assign busy        = (r_state != S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign res_data    = r_res;
  assign w_last      = (r_cnt == (r_len - LEN_W'(1)));
  assign w_accept    = (r_state == S_IDLE) & start & ~abort;
  // Back-to-back beats take the sum straight from the MAC; after a bubble
  // the parked copy in r_acc is used instead.
  assign mac_psum_in = r_pend ? mac_psum_out : r_acc;

  // Next-state decode; abort overrides everything.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len != '0) ? S_FEED : S_DONE;
      S_FEED:  if (w_beat && w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Job counters, partial-sum carry and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_pend <= 1'b0;
      r_res  <= '0;
    end else begin
      r_pend <= w_beat;
      if (r_pend) r_acc <= mac_psum_out;
      if (w_beat) r_cnt <= r_cnt + LEN_W'(1);
      if (r_state == S_DRAIN && !abort) r_res <= mac_psum_out;
      if (w_accept) begin
        if (len != '0) begin
          r_len  <= len;
          r_cnt  <= '0;
          r_acc  <= '0;
          r_pend <= 1'b0;
        end else begin
          r_res  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_int8_mac_seq.sv
// Bench for int8_mac_seq: behavioural MAC next to the DUT, directed and
// random jobs, expected sums computed as plain dot-product totals mod 2^24.
module tb_int8_mac_seq;

  localparam int VEC_W = 264;
  localparam int ACC_W = 24;
  localparam int LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_a;
  logic [VEC_W-1:0] in_b;
  logic             mac_en;
  logic [VEC_W-1:0] mac_a;
  logic [VEC_W-1:0] mac_b;
  logic [ACC_W-1:0] mac_psum_in;
  logic [ACC_W-1:0] mac_psum_out;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  int errors = 0;
  int checks = 0;

  int8_mac_seq #(.VEC_W(VEC_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_psum_in(mac_psum_in), .mac_psum_out(mac_psum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned dot(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 32; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
    return s;
  endfunction

  // MAC model: registered dot product plus incoming sum, zero when idle.
  logic [ACC_W-1:0] mac_q;
  always @(posedge clk) begin
    if (rst)         mac_q <= '0;
    else if (mac_en) mac_q <= mac_psum_in + ACC_W'(dot(mac_a, mac_b));
    else             mac_q <= '0;
  end
  assign mac_psum_out = mac_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] make_vec(input bit rnd, input logic [7:0] bval);
    logic [VEC_W-1:0] v;
    if (rnd) begin
      for (int w = 0; w < 9; w++) v[32*w +: 32] = $urandom;
    end else begin
      v = {33{bval}};
    end
    return v;
  endfunction

  // One complete job: start, feed with the given valid pattern, drain,
  // hold the result for 'hold' cycles (pulsing start), then accept it.
  task automatic run_job(input string tag, input int n, input bit rnd,
                         input logic [7:0] abyte, input logic [7:0] bbyte,
                         input logic [31:0] vmask, input bit use_mask,
                         input int hold, input bit has_exp, input int unsigned exp_lit);
    int unsigned exp_sum;
    int beats;
    int k;
    logic v;
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [ACC_W-1:0] held;
    exp_sum = 0;
    beats = 0;
    k = 0;
    start = 1'b1;
    len = LEN_W'(n);
    in_valid = 1'b0;
    #1;
    chk({tag, "_idle_busy"}, busy, 1'b0);
    tick();
    start = 1'b0;
    while (beats < n && k < 64 * n + 64) begin
      v = use_mask ? ((k < 32) ? vmask[k] : 1'b1) : ($urandom_range(0, 3) != 0);
      a = make_vec(rnd, abyte);
      b = make_vec(rnd, bbyte);
      in_a = a;
      in_b = b;
      in_valid = v;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      chk({tag, "_mac_en"}, mac_en, v);
      if (v) chk({tag, "_psum_in"}, mac_psum_in, exp_sum);
      tick();
      if (v) begin
        exp_sum = (exp_sum + dot(a, b)) & 32'h00FF_FFFF;
        beats++;
      end
      k++;
    end
    in_valid = 1'b0;
    chk({tag, "_beats"}, beats, n);
    #1;
    chk({tag, "_drain"}, {busy, in_ready, res_valid, mac_en}, 4'b1000);
    tick();
    chk({tag, "_res_valid"}, res_valid, 1'b1);
    chk({tag, "_res_data"}, res_data, exp_sum);
    if (has_exp) chk({tag, "_res_lit"}, res_data, exp_lit);
    held = res_data;
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len = LEN_W'($urandom_range(0, 9));
      tick();
      chk({tag, "_hold_valid"}, res_valid, 1'b1);
      chk({tag, "_hold_data"}, res_data, held);
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_post_busy"}, busy, 1'b0);
    chk({tag, "_post_valid"}, res_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_mac_en", mac_en, 1'b0);
    chk("rst_psum_in", mac_psum_in, 0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 0);
    rst = 1'b0;
    tick();

    run_job("len1_ones", 1, 1'b0, 8'd1, 8'd1, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, 32);
    run_job("len4_twos", 4, 1'b0, 8'd2, 8'd2, 32'hFFFF_FFFF, 1'b1, 2, 1'b1, 512);
    run_job("len3_bubbles", 3, 1'b0, 8'd1, 8'd1, 32'h0000_0029, 1'b1, 0, 1'b1, 96);
    run_job("len9_wrap", 9, 1'b0, 8'd255, 8'd255, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, 1949984);

    // len=0: result straight away, held while res_ready stays low.
    start = 1'b1;
    len = '0;
    tick();
    start = 1'b0;
    chk("len0_valid", res_valid, 1'b1);
    chk("len0_data", res_data, 0);
    for (int h = 0; h < 5; h++) begin
      start = 1'b1;
      len = 8'd3;
      tick();
      chk("len0_hold_valid", res_valid, 1'b1);
      chk("len0_hold_data", res_data, 0);
      chk("len0_hold_ready", in_ready, 1'b0);
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("len0_post_busy", busy, 1'b0);

    // Random jobs with random operands and bubbles.
    for (int j = 0; j < 6; j++) begin
      run_job("rand", $urandom_range(1, 12), 1'b1, 8'd0, 8'd0, 32'h0, 1'b0,
              $urandom_range(0, 3), 1'b0, 0);
    end

    // rst in the middle of FEED of a len=5 job.
    start = 1'b1;
    len = 8'd5;
    tick();
    start = 1'b0;
    in_a = {33{8'd1}};
    in_b = {33{8'd1}};
    in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_feed_mac_en", mac_en, 1'b0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rstf_busy", busy, 1'b0);
    chk("rstf_in_ready", in_ready, 1'b0);
    chk("rstf_mac_en", mac_en, 1'b0);
    chk("rstf_psum_in", mac_psum_in, 0);
    chk("rstf_res_valid", res_valid, 1'b0);
    chk("rstf_res_data", res_data, 0);
    tick();

    // abort together with a valid chunk in FEED: no beat, back to IDLE.
    start = 1'b1;
    len = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    abort = 1'b1;
    #1;
    chk("abort_feed_mac_en", mac_en, 1'b0);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_feed_busy", busy, 1'b0);

    // abort during DRAIN: no result ever appears.
    start = 1'b1;
    len = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    chk("abort_drain_state", {busy, in_ready}, 2'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int h = 0; h < 3; h++) begin
      chk("abort_drain_valid", res_valid, 1'b0);
      chk("abort_drain_busy", busy, 1'b0);
      tick();
    end

    run_job("after_abort", 1, 1'b0, 8'd1, 8'd1, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, 32);
    run_job("after_abort_rnd", 5, 1'b1, 8'd0, 8'd0, 32'h0, 1'b0, 1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
